// File: rtl/traffic_pkg.sv
// traffic_pkg: shared lamp, fault-cause and state encodings for the signal safety monitor
package traffic_pkg;
    localparam logic [1:0] LAMP_OFF   = 2'b00;
    localparam logic [1:0] LAMP_GREEN = 2'b01;
    localparam logic [1:0] LAMP_RED   = 2'b10;

    localparam logic [2:0] FC_NONE        = 3'b000;
    localparam logic [2:0] FC_CONFLICT    = 3'b001;
    localparam logic [2:0] FC_BAD_CODE    = 3'b010;
    localparam logic [2:0] FC_SHORT_GREEN = 3'b011;
    localparam logic [2:0] FC_SHORT_GAP   = 3'b100;

    localparam logic [1:0] ST_STARTUP = 2'd0;
    localparam logic [1:0] ST_MONITOR = 2'd1;
    localparam logic [1:0] ST_FAULT   = 2'd2;

    // 2'b00 and 2'b11 are not legal sequencer lamp codes
    function automatic logic lamp_invalid(input logic [1:0] code);
        return code[1] == code[0];
    endfunction
endpackage

// File: rtl/approach_run_timer.sv
// approach_run_timer: tracks one approach's green run and flags runs that end too short
module approach_run_timer
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] lamp,
    output logic       green,
    output logic       start,
    output logic       stop,
    output logic       short_run
);
    localparam int W = $clog2(MIN_GREEN + 1);
    localparam logic [W-1:0] RUN_MAX = W'(MIN_GREEN);

    logic         was_green_q, was_green_d;
    logic         valid_q, valid_d;
    logic [W-1:0] run_q, run_d;

    assign green     = lamp == LAMP_GREEN;
    assign start     = green && !was_green_q;
    assign stop      = was_green_q && !green;
    assign short_run = stop && valid_q && (run_q < RUN_MAX);

    // Count the current run (saturating); a run is judged only if its first cycle was enabled
    always_comb begin
        was_green_d = green;
        run_d       = !green ? '0 : start ? W'(1) : (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
        valid_d     = green && (start ? en : valid_q);
    end

    // Run tracking registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            was_green_q <= 1'b0;
            valid_q     <= 1'b0;
            run_q       <= '0;
        end else begin
            was_green_q <= was_green_d;
            valid_q     <= valid_d;
            run_q       <= run_d;
        end
    end
endmodule

// File: rtl/signal_safety_monitor.sv
// signal_safety_monitor: checks a 4-way sequencer's lamp codes and forces a safe flashing-red on faults
module signal_safety_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN    = 5,
    parameter int MIN_ALL_RED  = 2,
    parameter int STARTUP_TIME = 3,
    parameter int FLASH_HALF   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] r1,
    input  logic [1:0] r2,
    input  logic [1:0] r3,
    input  logic [1:0] r4,
    input  logic       clear,
    output logic [1:0] lamp1,
    output logic [1:0] lamp2,
    output logic [1:0] lamp3,
    output logic [1:0] lamp4,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       active
);
    localparam int CMAX = (STARTUP_TIME > 2 * FLASH_HALF) ? STARTUP_TIME : 2 * FLASH_HALF;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int GW   = $clog2(MIN_ALL_RED + 1);
    localparam logic [GW-1:0] GAP_MAX    = GW'(MIN_ALL_RED);
    localparam logic [CW-1:0] FLASH_LAST = CW'(2 * FLASH_HALF - 1);
    localparam logic [CW-1:0] FLASH_MID  = CW'(FLASH_HALF);

    logic [3:0][1:0] r_q, r_d, lamp;
    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      fault_code_q, fault_code_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            armed_q, armed_d;
    logic [3:0]      green, start, stop, short_run, bad;
    logic [2:0]      det_code;
    logic            mon, det, any_green, all_red, flash_off;

    for (genvar i = 0; i < 4; i++) begin : g_approach
        approach_run_timer #(.MIN_GREEN(MIN_GREEN)) u_timer (
            .clk       (clk),
            .rst       (rst),
            .en        (mon),
            .lamp      (r_q[i]),
            .green     (green[i]),
            .start     (start[i]),
            .stop      (stop[i]),
            .short_run (short_run[i])
        );
        assign bad[i]  = lamp_invalid(r_q[i]);
        assign lamp[i] = (mon && !det) ? r_q[i] : flash_off ? LAMP_OFF : LAMP_RED;
    end

    assign mon        = state_q == ST_MONITOR;
    assign any_green  = |green;
    assign all_red    = r_q == {4{LAMP_RED}};
    assign flash_off  = (state_q == ST_FAULT) && (cnt_q >= FLASH_MID);
    assign det        = mon && (det_code != FC_NONE);
    assign lamp1      = lamp[0];
    assign lamp2      = lamp[1];
    assign lamp3      = lamp[2];
    assign lamp4      = lamp[3];
    assign fault      = state_q == ST_FAULT;
    assign active     = mon;
    assign fault_code = fault_code_q;

    // Prioritised fault cause; x & (x-1) is non-zero when two or more approaches are green
    always_comb begin
        det_code = (green & (green - 4'd1)) != 4'd0 ? FC_CONFLICT :
                   |bad                             ? FC_BAD_CODE :
                   |short_run                       ? FC_SHORT_GREEN :
                   (armed_q && |start && gap_q < GAP_MAX) ? FC_SHORT_GAP : FC_NONE;
    end

    // Input capture, all-red gap length and gap-check arming after the first green end in MONITOR
    always_comb begin
        r_d     = {r4, r3, r2, r1};
        gap_d   = any_green ? '0 : (gap_q == GAP_MAX) ? gap_q : gap_q + 1'b1;
        armed_d = mon && !det && (armed_q || |stop);
    end

    // Mode sequencing: startup hold, monitoring, and latched fault with flash counter
    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        fault_code_d = fault_code_q;
        case (state_q)
            ST_STARTUP: begin
                cnt_d = cnt_q + 1'b1;
                if (int'(cnt_q) + 1 >= STARTUP_TIME) begin
                    state_d = ST_MONITOR;
                    cnt_d   = '0;
                end
            end
            ST_MONITOR: begin
                if (det) begin
                    state_d      = ST_FAULT;
                    fault_code_d = (fault_code_q == FC_NONE) ? det_code : fault_code_q;
                end
            end
            ST_FAULT: begin
                cnt_d = (cnt_q == FLASH_LAST) ? '0 : cnt_q + 1'b1;
                if (clear && all_red) begin
                    state_d      = ST_STARTUP;
                    cnt_d        = '0;
                    fault_code_d = FC_NONE;
                end
            end
            default: state_d = ST_STARTUP;
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q          <= {4{LAMP_RED}};
            state_q      <= ST_STARTUP;
            cnt_q        <= '0;
            fault_code_q <= FC_NONE;
            gap_q        <= '0;
            armed_q      <= 1'b0;
        end else begin
            r_q          <= r_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fault_code_q <= fault_code_d;
            gap_q        <= gap_d;
            armed_q      <= armed_d;
        end
    end
endmodule

// File: tb/tb_signal_safety_monitor.sv
// tb_signal_safety_monitor: directed checks of startup, mirroring, fault causes, flash, clear and reset
module tb_signal_safety_monitor;
    localparam logic [7:0] ALL_RED = 8'hAA;
    localparam logic [7:0] ALL_OFF = 8'h00;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic [1:0] r1, r2, r3, r4;
    logic [1:0] lamp1, lamp2, lamp3, lamp4;
    logic       fault, active;
    logic [2:0] fault_code;
    logic [7:0] lamps;
    int         n_chk = 0;
    int         n_fail = 0;

    assign lamps = {lamp1, lamp2, lamp3, lamp4};

    signal_safety_monitor #(
        .MIN_GREEN(5), .MIN_ALL_RED(2), .STARTUP_TIME(3), .FLASH_HALF(4)
    ) dut (
        .clk(clk), .rst(rst), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .clear(clear),
        .lamp1(lamp1), .lamp2(lamp2), .lamp3(lamp3), .lamp4(lamp4),
        .fault(fault), .fault_code(fault_code), .active(active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] v);
        {r1, r2, r3, r4} = v;
    endtask

    // Upstream sequencer: each approach green 5 cycles then 2 all-red cycles, r1..r4 in turn
    function automatic logic [7:0] seq(input int t);
        int p;
        logic [7:0] v;
        p = t % 28;
        v = ALL_RED;
        if (p % 7 < 5) v[7 - 2 * (p / 7) -: 2] = 2'b01;
        return v;
    endfunction

    task automatic reset_only();
        rst = 1'b1;
        clear = 1'b0;
        drive(ALL_RED);
        tick();
        tick();
        check("rst_lamps", lamps, ALL_RED);
        check("rst_fault", fault, 0);
        check("rst_code", fault_code, 0);
        check("rst_active", active, 0);
        rst = 1'b0;
    endtask

    task automatic enter_monitor();
        reset_only();
        tick();
        tick();
        tick();
        check("enter_active", active, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] prev;
        drive(ALL_RED);

        // Normal sequencer traffic: 3 startup cycles, then 1-cycle mirror with no fault
        reset_only();
        prev = seq(0);
        drive(prev);
        for (int k = 1; k <= 103; k++) begin
            tick();
            check("seq_lamps", lamps, (k < 3) ? ALL_RED : prev);
            check("seq_active", active, (k < 3) ? 0 : 1);
            check("seq_fault", fault, 0);
            prev = seq(k);
            drive(prev);
        end

        // Conflict: r1 and r2 green together, then flash RED 4 / OFF 4
        enter_monitor();
        drive(8'h5A);
        tick();
        check("conflict_lamps", lamps, ALL_RED);
        check("conflict_same_cycle_fault", fault, 0);
        drive(ALL_RED);
        tick();
        check("conflict_fault", fault, 1);
        check("conflict_code", fault_code, 3'b001);
        check("conflict_active", active, 0);
        for (int j = 0; j < 10; j++) begin
            if (j > 0) tick();
            check("flash_lamps", lamps, (j % 8 < 4) ? ALL_RED : ALL_OFF);
        end

        // Short green: r3 green for 3 cycles; later conflict leaves the code alone
        enter_monitor();
        drive(8'hA6);
        tick();
        check("short_mirror", lamps, 8'hA6);
        tick();
        tick();
        drive(ALL_RED);
        tick();
        check("short_det_lamps", lamps, ALL_RED);
        tick();
        check("short_fault", fault, 1);
        check("short_code", fault_code, 3'b011);
        drive(8'h5A);
        tick();
        tick();
        check("code_kept", fault_code, 3'b011);
        drive(ALL_RED);

        // Short gap: full 5-cycle r1 run, 1 all-red cycle, then r2 green
        enter_monitor();
        drive(8'h6A);
        for (int j = 0; j < 5; j++) tick();
        check("gap_mirror", lamps, 8'h6A);
        drive(ALL_RED);
        tick();
        drive(8'h9A);
        tick();
        check("min_green_ok", fault, 0);
        check("gap_det_lamps", lamps, ALL_RED);
        drive(ALL_RED);
        tick();
        check("gap_fault", fault, 1);
        check("gap_code", fault_code, 3'b100);

        // Clear ignored with r4 green, accepted with all red, then restart through STARTUP
        drive(8'hA9);
        tick();
        clear = 1'b1;
        tick();
        check("clear_ignored_fault", fault, 1);
        check("clear_ignored_code", fault_code, 3'b100);
        clear = 1'b0;
        drive(ALL_RED);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_fault", fault, 0);
        check("clear_code", fault_code, 0);
        check("clear_active", active, 0);
        check("clear_lamps", lamps, ALL_RED);
        tick();
        tick();
        check("restart_still_startup", active, 0);
        tick();
        check("restart_monitor", active, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_in_monitor", active, 1);

        // Asynchronous reset during the OFF phase of the flash
        enter_monitor();
        drive(8'h5A);
        tick();
        drive(ALL_RED);
        tick();
        for (int j = 0; j < 4; j++) tick();
        check("off_phase", lamps, ALL_OFF);
        #2 rst = 1'b1;
        #1;
        check("async_rst_lamps", lamps, ALL_RED);
        check("async_rst_fault", fault, 0);
        check("async_rst_code", fault_code, 0);
        check("async_rst_active", active, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
